// File: rtl/sys_defs.sv
// Shared processor-to-memory bus types and arbiter defaults.
// Combinational typedefs only; no latency or backpressure of its own.
package sys_defs;

  localparam int NUM_TAGS_DEFAULT     = 15;
  localparam int STARVE_LIMIT_DEFAULT = 8;
  localparam int TAG_W                = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;

  typedef enum logic {
    CLIENT_DC = 1'b0,
    CLIENT_IC = 1'b1
  } MEM_CLIENT;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'h0,
    ARB_HOLD_DC = 2'h1,
    ARB_HOLD_IC = 2'h2
  } ARB_STATE;

  typedef struct packed {
    logic      valid;
    MEM_CLIENT owner;
  } TAG_OWNER_ENTRY;

endpackage

// File: rtl/mem_tag_owner_table.sv
// Owner table for outstanding load tags: one allocate port, one lookup/clear port; lookup is
// combinational, updates land at the clock edge. Error checks built only with MEM_ARB_TAG_CHECK_EN.
module mem_tag_owner_table
  import sys_defs::*;
#(
  parameter int NUM_TAGS = NUM_TAGS_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_en,
  input  logic [TAG_W-1:0] alloc_tag,
  input  MEM_CLIENT        alloc_owner,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             lookup_hit,
  output MEM_CLIENT        lookup_owner,
  input  logic             ic_store,
  output logic             tag_err
);

  TAG_OWNER_ENTRY entry_q [NUM_TAGS+1];

  logic alloc_ok;
  logic lookup_in_range;

  assign alloc_ok        = alloc_en && (alloc_tag != '0) && (int'(alloc_tag) <= NUM_TAGS);
  assign lookup_in_range = (lookup_tag != '0) && (int'(lookup_tag) <= NUM_TAGS);
  assign lookup_hit      = lookup_in_range && entry_q[lookup_tag].valid;
  assign lookup_owner    = entry_q[lookup_tag].owner;

  // Clear first, then allocate: a same-tag allocation in the return cycle wins.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= NUM_TAGS; i++) entry_q[i] <= '0;
    end else begin
      if (lookup_hit) entry_q[lookup_tag].valid <= 1'b0;
      if (alloc_ok) entry_q[alloc_tag] <= '{valid: 1'b1, owner: alloc_owner};
    end
  end

`ifdef MEM_ARB_TAG_CHECK_EN
  logic tag_err_q;
  logic err_now;

  assign err_now = ((lookup_tag != '0) && !lookup_hit)
                || (alloc_ok && entry_q[alloc_tag].valid && !(lookup_hit && (lookup_tag == alloc_tag)))
                || ic_store;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) tag_err_q <= 1'b0;
    else       tag_err_q <= tag_err_q | err_now;
  end

  assign tag_err = tag_err_q;
`else
  logic unused_ic_store;
  assign unused_ic_store = ic_store;
  assign tag_err         = 1'b0;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Dcache/Icache arbiter for the single memory port; grant and response routing are same-cycle
// combinational, a refused request holds the grant until accepted or withdrawn. Optional MEM_ARB_TAG_CHECK_EN.
module mem_bus_arbiter
  import sys_defs::*;
#(
  parameter int NUM_TAGS     = NUM_TAGS_DEFAULT,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT,
  parameter int CNT_W        = $clog2(STARVE_LIMIT) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  dc_command,
  input  logic [63:0] dc_addr,
  input  logic [63:0] dc_data,
  output logic [3:0]  dc_response,
  output logic [3:0]  dc_tag,
  output logic [63:0] dc_rdata,
  input  logic [1:0]  ic_command,
  input  logic [63:0] ic_addr,
  output logic [3:0]  ic_response,
  output logic [3:0]  ic_tag,
  output logic [63:0] ic_rdata,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,
  output logic        tag_err
);

  ARB_STATE         state_q, state_d;
  logic [CNT_W-1:0] starve_q;
  logic             ic_starved;
  logic             grant_ic;
  logic [1:0]       gnt_cmd;
  logic             gnt_live;
  logic             accepted;
  logic [3:0]       resp_vis;
  logic             lookup_hit;
  MEM_CLIENT        lookup_owner;

  assign ic_starved = (starve_q == CNT_W'(STARVE_LIMIT)) && (ic_command != BUS_NONE);

  always_comb begin
    grant_ic = 1'b0;
    state_d  = state_q;
    case (state_q)
      ARB_IDLE:    grant_ic = !((dc_command != BUS_NONE) && !ic_starved);
      ARB_HOLD_DC: grant_ic = 1'b0;
      ARB_HOLD_IC: grant_ic = 1'b1;
      default:     grant_ic = 1'b0;
    endcase
    if ((gnt_cmd == BUS_NONE) || (mem2proc_response != 4'd0)) state_d = ARB_IDLE;
    else state_d = grant_ic ? ARB_HOLD_IC : ARB_HOLD_DC;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ARB_IDLE;
    else       state_q <= state_d;
  end

  // Reset masks the port so clients see nothing while they are being reset themselves.
  assign gnt_cmd  = grant_ic ? ic_command : dc_command;
  assign gnt_live = !reset && (gnt_cmd != BUS_NONE);
  assign accepted = gnt_live && (mem2proc_response != 4'd0);
  assign resp_vis = gnt_live ? mem2proc_response : 4'd0;

  assign proc2mem_command = gnt_live ? gnt_cmd : BUS_NONE;
  assign proc2mem_addr    = !gnt_live ? 64'd0 : (grant_ic ? ic_addr : dc_addr);
  assign proc2mem_data    = (gnt_live && !grant_ic) ? dc_data : 64'd0;
  assign dc_response      = grant_ic ? 4'd0 : resp_vis;
  assign ic_response      = grant_ic ? resp_vis : 4'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_q <= '0;
    end else if ((ic_command == BUS_NONE) || (grant_ic && accepted)) begin
      starve_q <= '0;
    end else if (!grant_ic && (starve_q != CNT_W'(STARVE_LIMIT))) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  mem_tag_owner_table #(.NUM_TAGS(NUM_TAGS)) u_owner_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (accepted && (gnt_cmd == BUS_LOAD)),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (grant_ic ? CLIENT_IC : CLIENT_DC),
    .lookup_tag   (mem2proc_tag),
    .lookup_hit   (lookup_hit),
    .lookup_owner (lookup_owner),
    .ic_store     (!reset && (ic_command == BUS_STORE)),
    .tag_err      (tag_err)
  );

  assign dc_tag   = (lookup_hit && (lookup_owner == CLIENT_DC)) ? mem2proc_tag  : 4'd0;
  assign dc_rdata = (lookup_hit && (lookup_owner == CLIENT_DC)) ? mem2proc_data : 64'd0;
  assign ic_tag   = (lookup_hit && (lookup_owner == CLIENT_IC)) ? mem2proc_tag  : 4'd0;
  assign ic_rdata = (lookup_hit && (lookup_owner == CLIENT_IC)) ? mem2proc_data : 64'd0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a tag/owner model.
module tb_mem_bus_arbiter;
  import sys_defs::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  dc_command, ic_command, proc2mem_command;
  logic [63:0] dc_addr, dc_data, ic_addr, dc_rdata, ic_rdata;
  logic [63:0] proc2mem_addr, proc2mem_data, mem2proc_data;
  logic [3:0]  dc_response, dc_tag, ic_response, ic_tag;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic        tag_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
    .dc_response(dc_response), .dc_tag(dc_tag), .dc_rdata(dc_rdata),
    .ic_command(ic_command), .ic_addr(ic_addr),
    .ic_response(ic_response), .ic_tag(ic_tag), .ic_rdata(ic_rdata),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_tag(mem2proc_tag), .mem2proc_data(mem2proc_data),
    .tag_err(tag_err)
  );

  task automatic idle_inputs();
    dc_command = BUS_NONE; dc_addr = '0; dc_data = '0;
    ic_command = BUS_NONE; ic_addr = '0;
    mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    #1;
    checks++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 64'd0 || proc2mem_data !== 64'd0) begin
      errors++; $display("FAIL reset_port cmd=%0d addr=%h data=%h want 0", proc2mem_command, proc2mem_addr, proc2mem_data); end
    checks++; if (dc_response !== 4'd0 || ic_response !== 4'd0 || dc_tag !== 4'd0 || ic_tag !== 4'd0) begin
      errors++; $display("FAIL reset_tags dcr=%0d icr=%0d dct=%0d ict=%0d want 0", dc_response, ic_response, dc_tag, ic_tag); end
    checks++; if (dc_rdata !== 64'd0 || ic_rdata !== 64'd0 || tag_err !== 1'b0) begin
      errors++; $display("FAIL reset_data dcd=%h icd=%h err=%b want 0", dc_rdata, ic_rdata, tag_err); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single_load();
    do_reset();
    @(negedge clock);
    dc_command = BUS_LOAD; dc_addr = 64'h100; mem2proc_response = 4'd3;
    #1;
    checks++; if (proc2mem_addr !== 64'h100 || proc2mem_command !== BUS_LOAD) begin
      errors++; $display("FAIL load_port addr=%h cmd=%0d want 100/1", proc2mem_addr, proc2mem_command); end
    checks++; if (dc_response !== 4'd3 || ic_response !== 4'd0) begin
      errors++; $display("FAIL load_resp dc=%0d ic=%0d want 3/0", dc_response, ic_response); end
    @(negedge clock);
    idle_inputs();
    mem2proc_tag = 4'd3; mem2proc_data = 64'hDEAD;
    #1;
    checks++; if (dc_tag !== 4'd3 || dc_rdata !== 64'hDEAD || ic_tag !== 4'd0) begin
      errors++; $display("FAIL load_return dct=%0d dcd=%h ict=%0d want 3/dead/0", dc_tag, dc_rdata, ic_tag); end
  endtask

  task automatic test_hold();
    logic [3:0] resp [3] = '{4'd0, 4'd0, 4'd5};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      dc_command = BUS_LOAD; dc_addr = 64'h200; ic_command = BUS_LOAD; ic_addr = 64'h300;
      mem2proc_response = resp[c];
      #1;
      checks++; if (proc2mem_addr !== 64'h200 || dc_response !== resp[c] || ic_response !== 4'd0) begin
        errors++; $display("FAIL hold_c%0d addr=%h dcr=%0d icr=%0d want 200/%0d/0", c, proc2mem_addr, dc_response, ic_response, resp[c]); end
    end
    @(negedge clock);
    dc_command = BUS_NONE; mem2proc_response = 4'd0;
    checks++; if (dut.state_q !== ARB_IDLE || dut.starve_q !== 4'd3) begin
      errors++; $display("FAIL hold_after state=%0d starve=%0d want 0/3", dut.state_q, dut.starve_q); end
  endtask

  task automatic test_starvation();
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      dc_command = BUS_LOAD; dc_addr = 64'h1000 + 64'(c);
      ic_command = BUS_LOAD; ic_addr = 64'h2000 + 64'(c);
      mem2proc_response = 4'(c);
      #1;
      checks++; if (ic_response !== ((c == 9) ? 4'(c) : 4'd0) || dc_response !== ((c == 9) ? 4'd0 : 4'(c))) begin
        errors++; $display("FAIL starve_c%0d dcr=%0d icr=%0d (Icache grant expected only on cycle 9)", c, dc_response, ic_response); end
    end
  endtask

  task automatic test_store_no_return();
    logic exp_err;
`ifdef MEM_ARB_TAG_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_reset();
    @(negedge clock);
    dc_command = BUS_STORE; dc_addr = 64'h40; dc_data = 64'h55; mem2proc_response = 4'd2;
    #1;
    checks++; if (proc2mem_command !== BUS_STORE || proc2mem_data !== 64'h55 || dc_response !== 4'd2) begin
      errors++; $display("FAIL store_port cmd=%0d data=%h dcr=%0d want 2/55/2", proc2mem_command, proc2mem_data, dc_response); end
    @(negedge clock);
    idle_inputs();
    mem2proc_tag = 4'd2; mem2proc_data = 64'h77;
    #1;
    checks++; if (dc_tag !== 4'd0 || ic_tag !== 4'd0) begin
      errors++; $display("FAIL store_return dct=%0d ict=%0d want 0/0", dc_tag, ic_tag); end
    @(negedge clock);
    idle_inputs();
    #1;
    checks++; if (tag_err !== exp_err) begin
      errors++; $display("FAIL store_tag_err got %b want %b", tag_err, exp_err); end
  endtask

  task automatic test_same_tag();
    do_reset();
    @(negedge clock);
    ic_command = BUS_LOAD; ic_addr = 64'h700; mem2proc_response = 4'd7;
    #1;
    checks++; if (ic_response !== 4'd7) begin
      errors++; $display("FAIL same_alloc_ic icr=%0d want 7", ic_response); end
    @(negedge clock);
    idle_inputs();
    dc_command = BUS_LOAD; dc_addr = 64'h780; mem2proc_response = 4'd7;
    mem2proc_tag = 4'd7; mem2proc_data = 64'hAAAA;
    #1;
    checks++; if (ic_tag !== 4'd7 || ic_rdata !== 64'hAAAA || dc_tag !== 4'd0 || dc_response !== 4'd7) begin
      errors++; $display("FAIL same_cycle ict=%0d icd=%h dct=%0d dcr=%0d want 7/aaaa/0/7", ic_tag, ic_rdata, dc_tag, dc_response); end
    @(negedge clock);
    idle_inputs();
    mem2proc_tag = 4'd7; mem2proc_data = 64'hBBBB;
    #1;
    checks++; if (dc_tag !== 4'd7 || dc_rdata !== 64'hBBBB || ic_tag !== 4'd0 || tag_err !== 1'b0) begin
      errors++; $display("FAIL same_next dct=%0d dcd=%h ict=%0d err=%b want 7/bbbb/0/0", dc_tag, dc_rdata, ic_tag, tag_err); end
  endtask

  task automatic test_async_reset();
    logic [3:0] tags [3] = '{4'd1, 4'd2, 4'd4};
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      idle_inputs();
      if (c < 2) begin dc_command = BUS_LOAD; dc_addr = 64'h800 + 64'(c); end
      else begin ic_command = BUS_LOAD; ic_addr = 64'h880; end
      mem2proc_response = tags[c];
    end
    @(negedge clock);
    idle_inputs();
    ic_command = BUS_LOAD; ic_addr = 64'h900;
    @(negedge clock);
    dc_command = BUS_LOAD; dc_addr = 64'hA00;
    #1;
    checks++; if (proc2mem_addr !== 64'h900 || dut.state_q !== ARB_HOLD_IC) begin
      errors++; $display("FAIL hold_ic addr=%h state=%0d want 900/2", proc2mem_addr, dut.state_q); end
    #1;
    reset = 1'b1; mem2proc_tag = 4'd1; mem2proc_data = 64'h1234;
    #1;
    checks++; if (proc2mem_command !== 2'd0 || proc2mem_addr !== 64'd0 || ic_response !== 4'd0 || dc_response !== 4'd0) begin
      errors++; $display("FAIL arst_port cmd=%0d addr=%h icr=%0d dcr=%0d want 0", proc2mem_command, proc2mem_addr, ic_response, dc_response); end
    checks++; if (dc_tag !== 4'd0 || ic_tag !== 4'd0 || dut.state_q !== ARB_IDLE) begin
      errors++; $display("FAIL arst_state dct=%0d ict=%0d state=%0d want 0", dc_tag, ic_tag, dut.state_q); end
    @(negedge clock);
    idle_inputs();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      mem2proc_tag = tags[c]; mem2proc_data = 64'hFACE;
      #1;
      checks++; if (dc_tag !== 4'd0 || ic_tag !== 4'd0) begin
        errors++; $display("FAIL arst_return_t%0d dct=%0d ict=%0d want 0/0", tags[c], dc_tag, ic_tag); end
    end
  endtask

  // Model: per-tag owner (-1 = free), which client holds the bus (-1 = none), Icache wait count.
  task automatic test_random();
    int owner [16];
    int held, starve, g, r, t;
    int freel [$];
    int outst [$];
    logic [1:0]  dcc, icc, gcmd;
    logic [63:0] rd, da, ia, dd;
    held = -1; starve = 0;
    for (int i = 0; i < 16; i++) owner[i] = -1;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      dcc = 2'($urandom_range(2, 0));
      icc = ($urandom_range(2, 0) != 0) ? BUS_LOAD : BUS_NONE;
      da = {$urandom, $urandom}; ia = {$urandom, $urandom}; dd = {$urandom, $urandom};
      if (held >= 0) g = held;
      else if (dcc != BUS_NONE && !(starve == STARVE_LIMIT_DEFAULT && icc != BUS_NONE)) g = 0;
      else g = 1;
      gcmd = (g == 1) ? icc : dcc;
      freel.delete(); outst.delete();
      for (int i = 1; i < 16; i++) if (owner[i] < 0) freel.push_back(i); else outst.push_back(i);
      r = 0;
      if (gcmd != BUS_NONE && $urandom_range(9, 0) >= 3 && freel.size() > 0)
        r = freel[$urandom_range(freel.size() - 1, 0)];
      t = 0;
      if ($urandom_range(9, 0) < 4 && outst.size() > 0) t = outst[$urandom_range(outst.size() - 1, 0)];
      else if ($urandom_range(9, 0) == 0) t = int'($urandom_range(15, 1));
      rd = {$urandom, $urandom};
      dc_command = dcc; dc_addr = da; dc_data = dd; ic_command = icc; ic_addr = ia;
      mem2proc_response = 4'(r); mem2proc_tag = 4'(t); mem2proc_data = rd;
      #1;
      checks++; if (proc2mem_command !== gcmd || (gcmd != BUS_NONE && proc2mem_addr !== ((g == 1) ? ia : da))) begin
        errors++; $display("FAIL rnd_port c=%0d cmd=%0d addr=%h want cmd %0d from client %0d", c, proc2mem_command, proc2mem_addr, gcmd, g); end
      if (g == 0 && gcmd != BUS_NONE) begin
        checks++; if (proc2mem_data !== dd) begin
          errors++; $display("FAIL rnd_data c=%0d got %h want %h", c, proc2mem_data, dd); end
      end
      checks++; if (dc_response !== ((g == 0) ? 4'(r) : 4'd0) || ic_response !== ((g == 1) ? 4'(r) : 4'd0)) begin
        errors++; $display("FAIL rnd_resp c=%0d dcr=%0d icr=%0d want tag %0d to client %0d", c, dc_response, ic_response, r, g); end
      checks++; if (dc_tag !== ((t != 0 && owner[t] == 0) ? 4'(t) : 4'd0) || dc_rdata !== ((t != 0 && owner[t] == 0) ? rd : 64'd0)) begin
        errors++; $display("FAIL rnd_dc_ret c=%0d tag=%0d data=%h for return tag %0d owner %0d", c, dc_tag, dc_rdata, t, owner[t]); end
      checks++; if (ic_tag !== ((t != 0 && owner[t] == 1) ? 4'(t) : 4'd0) || ic_rdata !== ((t != 0 && owner[t] == 1) ? rd : 64'd0)) begin
        errors++; $display("FAIL rnd_ic_ret c=%0d tag=%0d data=%h for return tag %0d owner %0d", c, ic_tag, ic_rdata, t, owner[t]); end
      if (t != 0) owner[t] = -1;
      if (gcmd == BUS_LOAD && r != 0) owner[r] = g;
      held = (gcmd != BUS_NONE && r == 0) ? g : -1;
      if (icc == BUS_NONE || (g == 1 && r != 0)) starve = 0;
      else if (g != 1 && starve < STARVE_LIMIT_DEFAULT) starve++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_load();
    test_hold();
    test_starvation();
    test_store_no_return();
    test_same_tag();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
